tile_accumulator: RTL and testbench
===================================

Name: tile_accumulator

Overview:
- Downstream stage of the 4-lane threadgroup dot-product array. It consumes the four 16-bit signed FEDP results per step and accumulates them over a configurable number of K-steps in wide registers.
- At the end of each tile it saturates the four sums, packs them into one 64-bit word, and hands it to writeback through a 2-entry output FIFO with valid/ready.
- In this configuration the array's partial-sum inputs are driven with zero. All K-reduction happens here.

Parameters:
- ACC_W, 24, accumulator width per lane (signed).
- OUT_W, 16, output width per lane after saturation.
- CNT_W, 8, step-counter width. Tile length range is 1..2^CNT_W.
- FIFO_DEPTH, 2, output FIFO entries (power of two, at least 2).

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- cfg_k_steps  in  CNT_W  steps per tile. 0 encodes 2^CNT_W. Sampled on the first beat of each tile.
- in_valid  in  1  four results present.
- in_ready  out  1  beat accepted when in_valid&&in_ready.
- in_res0..in_res3  in  16 each  signed FEDP results, lanes 0..3.
- out_valid  out  1  tile word available.
- out_ready  in  1  consumer accepts.
- out_data  out  4*OUT_W  lane n at bits [n*OUT_W +: OUT_W].
- out_sat  out  4  per-lane saturation flag for the word on out_data.
- busy  out  1  high while a tile is partially accumulated or the FIFO is non-empty.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - State IDLE, step_cnt=0, accumulators 0, FIFO empty.
  - out_valid=0, out_data=0, out_sat=0, busy=0.
  - in_ready=1 from the first cycle after reset.
  - Reset asserted mid-tile or with the FIFO holding data discards everything. No output is produced for the aborted tile.
- States:
  - IDLE: no tile open. An accepted beat loads k_lat=cfg_k_steps, sets acc_n=sext(in_res_n), step_cnt=1, and moves to ACCUM. If k_lat encodes 1, this beat is also the last beat.
  - ACCUM: each accepted beat does acc_n += sext(in_res_n) and step_cnt++. No beat means everything holds; gaps of any length are allowed.
  - Last beat: the beat that makes step_cnt equal the latched length. It pushes the finished word into the FIFO and returns to IDLE.
- Arithmetic:
  - Accumulation is two's-complement and wraps at ACC_W.
  - Output saturation: values above +(2^(OUT_W-1)-1) or below -2^(OUT_W-1) are clamped, and the lane's sat flag is set.
  - The saturation is computed from the final sum, including the last beat.
- in_ready rule: in_ready = !(last-beat-pending && fifo_full). Here last-beat-pending means the next accepted beat would be the last beat.
  - in_ready is registered or derived from state only. It has no combinational path from out_ready.
  - A pop in the same cycle does not raise in_ready.
- Latency: last beat accepted in cycle t gives out_valid=1 in cycle t+1.
- FIFO behaviour:
  - In-order.
  - Simultaneous push and pop is legal when the FIFO is not empty, and the count is unchanged.
  - out_data and out_sat are stable while out_valid && !out_ready.
  - Empty: out_valid=0 and out_data holds its last value.
- Configuration: a cfg_k_steps change mid-tile is ignored until the next tile.

Optional Feature:
- Macro TACC_RELU_EN.
- Defined: each lane's final sum is clamped to 0 when negative, before saturation. The sat flag is set only on positive overflow.
- Undefined: signed saturation as above. The build has no ReLU logic.

Decomposition:
- Package tacc_pkg holds:
  - the ACC_W and OUT_W defaults;
  - the state enum (IDLE, ACCUM);
  - a saturate function (ACC_W to OUT_W, returns value and flag);
  - lane-pack/unpack helpers.
- One sub-module, tacc_out_fifo: synchronous FIFO of width 4*OUT_W+4, depth FIFO_DEPTH, with full/empty/count outputs.

Test Plan:
- Basic: cfg_k_steps=4, four beats with in_res={1,2,3,4} each step. Required: one word with lanes {4,8,12,16}, sat=0, out_valid in the cycle after the 4th acceptance.
- Saturation: cfg_k_steps=3, lane0=+20000 ×3, lane1=-20000 ×3. Required: lane0=32767, lane1=-32768, out_sat=4'b0011. With TACC_RELU_EN: lane1=0 and out_sat=4'b0001.
- Encoding and single-step: cfg_k_steps=0 with 256 beats of lane value 1. Required: lane=256 and exactly one word. cfg_k_steps=1 gives one word per beat.
- Backpressure: cfg_k_steps=1, out_ready=0, 3 beats. Required: 2 words queued, in_ready=0 before the 3rd beat. Raise out_ready: words pop in order, then the 3rd beat is accepted, with no loss or duplication.
- Reset mid-tile: 2 of 4 beats accepted, then rst pulsed 1 cycle. Required: all outputs at reset values and no word emitted. The next 4-beat tile produces a correct sum unaffected by the stale beats.
- Bubbles and config change: cfg_k_steps=4 with in_valid gaps of 0–5 cycles, and cfg_k_steps changed to 2 mid-tile. Required: the current tile uses 4 steps and the next tile uses 2.

Source files
------------

// File: rtl/tacc_pkg.sv
// tacc_pkg: shared types and helpers for the tile accumulator.
//   - ACC_W_DEF / OUT_W_DEF : default accumulator and output lane widths
//   - state_t               : tile FSM states (IDLE, ACCUM)
//   - lane_vec_t            : four output lanes, lane n at bits [n*OUT_W +: OUT_W]
//   - saturate()            : clamps an ACC_W sum to OUT_W and reports the clamp
//   - pack_lanes() / unpack_lanes() : convert between lane vector and flat word
// The helpers are sized to the package default widths.
package tacc_pkg;

    localparam int ACC_W_DEF = 24;
    localparam int OUT_W_DEF = 16;
    localparam int LANES     = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    typedef logic [LANES-1:0][OUT_W_DEF-1:0] lane_vec_t;

    typedef struct packed {
        logic [OUT_W_DEF-1:0] value;
        logic                 flag;
    } sat_t;

    localparam logic signed [ACC_W_DEF-1:0] SAT_MAX = ACC_W_DEF'(2**(OUT_W_DEF-1) - 1);
    localparam logic signed [ACC_W_DEF-1:0] SAT_MIN = ACC_W_DEF'(-(2**(OUT_W_DEF-1)));

    function automatic sat_t saturate(input logic signed [ACC_W_DEF-1:0] v);
        sat_t r;
        if (v > SAT_MAX) begin
            r.value = SAT_MAX[OUT_W_DEF-1:0];
            r.flag  = 1'b1;
        end else if (v < SAT_MIN) begin
            r.value = SAT_MIN[OUT_W_DEF-1:0];
            r.flag  = 1'b1;
        end else begin
            r.value = v[OUT_W_DEF-1:0];
            r.flag  = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [LANES*OUT_W_DEF-1:0] pack_lanes(input lane_vec_t l);
        return l;
    endfunction

    function automatic lane_vec_t unpack_lanes(input logic [LANES*OUT_W_DEF-1:0] w);
        return w;
    endfunction

endpackage

// File: rtl/tacc_out_fifo.sv
// tacc_out_fifo: small synchronous in-order FIFO holding finished tile words.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   push, din      : write request and word
//   pop, dout      : read request and head word
//   full, empty    : occupancy flags
//   count          : number of words held
// When empty, dout keeps showing the last word that was popped (0 after reset).
module tacc_out_fifo #(
    parameter  int W     = 68,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [W-1:0]  hold;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? hold : mem[rd_ptr];

    // NOTE: storage has no reset; occupancy is tracked by count, so stale
    // entries are never visible and the array maps onto plain registers/RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/tile_accumulator.sv
// tile_accumulator: accumulates four signed 16-bit dot-product results per
// step over a tile of cfg_k_steps beats, saturates the four sums, and queues
// the packed word for writeback.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cfg_k_steps              : tile length (0 means 2^CNT_W), latched on a tile's first beat
//   in_valid / in_ready      : input handshake; in_res0..in_res3 are the lane results
//   out_valid / out_ready    : output handshake; out_data lane n at [n*OUT_W +: OUT_W]
//   out_sat                  : per-lane saturation flag of the word on out_data
//   busy                     : a tile is partially accumulated or words are queued
// Build option: define TACC_RELU_EN to clamp negative sums to zero before
// saturation (only positive overflow then sets a sat flag).
module tile_accumulator
    import tacc_pkg::*;
#(
    parameter int ACC_W      = ACC_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   cfg_k_steps,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_res0,
    input  logic [15:0]        in_res1,
    input  logic [15:0]        in_res2,
    input  logic [15:0]        in_res3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*OUT_W-1:0] out_data,
    output logic [3:0]         out_sat,
    output logic               busy
);

    localparam int WORD_W = 4*OUT_W + 4;
    localparam int FCW    = $clog2(FIFO_DEPTH) + 1;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W:0]          step_cnt;
    logic [CNT_W-1:0]        k_lat;
    logic [CNT_W:0]          tile_len;
    logic signed [15:0]      res [LANES];
    logic signed [ACC_W-1:0] acc [LANES];
    logic signed [ACC_W-1:0] sum [LANES];
    logic                    last_pending;
    logic                    beat;
    logic                    push;
    lane_vec_t               lane_v;
    logic [3:0]              sat_v;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [FCW-1:0]          fifo_count;
    logic [WORD_W-1:0]       fifo_dout;

    assign res[0] = in_res0;
    assign res[1] = in_res1;
    assign res[2] = in_res2;
    assign res[3] = in_res3;

    // Latched length, with the all-zeros code standing for 2^CNT_W.
    assign tile_len = (k_lat == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, k_lat};

    assign beat = in_valid && in_ready;
    assign push = beat && last_pending;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (beat && !last_pending) state_nxt = ACCUM;
            ACCUM:   if (push)                  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs. in_ready depends only on state, configuration and FIFO
    // occupancy, never on out_ready, so a same-cycle pop cannot raise it.
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        last_pending = 1'b0;
        case (state)
            IDLE:    last_pending = (cfg_k_steps == CNT_W'(1));
            ACCUM:   last_pending = (step_cnt + 1'b1 == tile_len);
            default: last_pending = 1'b0;
        endcase
        in_ready = !(last_pending && fifo_full);
    end

    // Sum including the current beat; a tile's first beat starts from zero.
    // This is both the next accumulator value and the source of the output
    // word on the last beat.
    always_comb begin
        logic signed [ACC_W-1:0] v;
        sat_t                    sr;
        for (int n = 0; n < LANES; n++) begin
            sum[n] = ((state == ACCUM) ? acc[n] : ACC_W'(0)) + ACC_W'(res[n]);
            v      = sum[n];
`ifdef TACC_RELU_EN
            if (v[ACC_W-1]) begin
                v = '0;
            end
`endif
            sr        = saturate(ACC_W_DEF'(v));
            lane_v[n] = sr.value;
            sat_v[n]  = sr.flag;
        end
    end

    // Accumulators and step counter only move on an accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt <= '0;
            k_lat    <= '0;
            for (int n = 0; n < LANES; n++) begin
                acc[n] <= '0;
            end
        end else if (beat) begin
            if (state == IDLE) begin
                k_lat    <= cfg_k_steps;
                step_cnt <= (CNT_W+1)'(1);
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
            for (int n = 0; n < LANES; n++) begin
                acc[n] <= sum[n];
            end
        end
    end

    tacc_out_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({sat_v, pack_lanes(lane_v)}),
        .pop   (out_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_dout[4*OUT_W-1:0];
    assign out_sat   = fifo_dout[WORD_W-1 -: 4];
    assign busy      = (state == ACCUM) || (fifo_count != '0);

endmodule

// File: tb/tb_tile_accumulator.sv
`timescale 1ns/1ps
module tb_tile_accumulator;
    import tacc_pkg::*;

    localparam int FIFO_DEPTH = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         cfg_k_steps;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] res_cur [4];
    logic [15:0]        in_res0, in_res1, in_res2, in_res3;
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        out_data;
    logic [3:0]         out_sat;
    logic               busy;

    assign in_res0 = res_cur[0];
    assign in_res1 = res_cur[1];
    assign in_res2 = res_cur[2];
    assign in_res3 = res_cur[3];

    always #5 clk = ~clk;

    tile_accumulator dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_k_steps (cfg_k_steps),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_res0     (in_res0),
        .in_res1     (in_res1),
        .in_res2     (in_res2),
        .in_res3     (in_res3),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .busy        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (tile/queue level) ----------------
    typedef struct packed {
        logic [3:0]  sat;
        logic [63:0] data;
    } word_t;

    word_t  mq[$];          // words the FIFO should hold, head first
    word_t  m_last;         // word shown while empty
    word_t  got[$];         // words actually popped from the DUT
    bit     m_open;
    int     m_cnt;
    int     m_len;
    longint m_sum [4];
    logic [7:0] k_drive;

    logic        snap_valid;
    logic [63:0] snap_data;
    logic [3:0]  snap_sat;
    logic        snap_busy;

    function automatic int len_of(input logic [7:0] k);
        return (k == 8'd0) ? 256 : int'(k);
    endfunction

    function automatic longint wrap_acc(input longint x);
        longint m = longint'(1) << 24;
        longint y = x % m;
        if (y < 0) y += m;
        if (y >= m / 2) y -= m;
        return y;
    endfunction

    function automatic word_t finish_word();
        word_t  w = '0;
        longint v;
        for (int n = 0; n < 4; n++) begin
            v = m_sum[n];
`ifdef TACC_RELU_EN
            if (v < 0) v = 0;
`endif
            if (v > 32767) begin
                v = 32767;
                w.sat[n] = 1'b1;
            end else if (v < -32768) begin
                v = -32768;
                w.sat[n] = 1'b1;
            end
            w.data[n*16 +: 16] = 16'(v);
        end
        return w;
    endfunction

    function automatic bit m_last_pending();
        return m_open ? (m_cnt + 1 == m_len) : (len_of(cfg_k_steps) == 1);
    endfunction

    function automatic bit m_in_ready();
        return !(m_last_pending() && mq.size() == FIFO_DEPTH);
    endfunction

    // Advance the model across the coming clock edge using the driven inputs.
    task automatic model_step();
        bit beat;
        bit pop;
        if (rst) begin
            mq.delete();
            m_last = '0;
            m_open = 1'b0;
            m_cnt  = 0;
            return;
        end
        beat = in_valid && m_in_ready();
        pop  = (mq.size() != 0) && out_ready;
        if (pop) begin
            got.push_back({out_sat, out_data});
            m_last = mq.pop_front();
        end
        if (beat) begin
            if (!m_open) begin
                m_len  = len_of(cfg_k_steps);
                m_cnt  = 0;
                m_open = 1'b1;
                for (int n = 0; n < 4; n++) m_sum[n] = 0;
            end
            m_cnt++;
            for (int n = 0; n < 4; n++) m_sum[n] = wrap_acc(m_sum[n] + longint'(res_cur[n]));
            if (m_cnt == m_len) begin
                mq.push_back(finish_word());
                m_open = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        word_t e = (mq.size() != 0) ? mq[0] : m_last;
        check("out_valid", out_valid, mq.size() != 0);
        check("out_data", out_data, e.data);
        check("out_sat", out_sat, e.sat);
        check("busy", busy, m_open || mq.size() != 0);
    endtask

    // One clock: compare state at the falling edge, drive inputs, check
    // in_ready against the model, then step the model.
    task automatic do_cycle(input logic r, input logic v, input lane_vec_t res, input logic ordy);
        @(negedge clk);
        snap_valid = out_valid;
        snap_data  = out_data;
        snap_sat   = out_sat;
        snap_busy  = busy;
        check_outputs();
        rst         = r;
        in_valid    = v;
        out_ready   = ordy;
        cfg_k_steps = k_drive;
        for (int n = 0; n < 4; n++) res_cur[n] = res[n];
        #1;
        if (!r) check("in_ready", in_ready, m_in_ready());
        model_step();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [7:0] k;
        logic [8:0] nbeats;
        lane_vec_t  res;
        lane_vec_t  expv;
        logic [3:0] exp_sat;
    } vec_t;

    vec_t      tbl [5];
    lane_vec_t zero_res = '0;

    initial begin
        int g0;
        lane_vec_t r;

        tbl[0] = '{k: 8'd4, nbeats: 9'd4,
                   res:  {16'd4, 16'd3, 16'd2, 16'd1},
                   expv: {16'd16, 16'd12, 16'd8, 16'd4}, exp_sat: 4'b0000};
        tbl[2] = '{k: 8'd0, nbeats: 9'd256,
                   res:  {16'd1, 16'd1, 16'd1, 16'd1},
                   expv: {16'd256, 16'd256, 16'd256, 16'd256}, exp_sat: 4'b0000};
`ifdef TACC_RELU_EN
        tbl[1] = '{k: 8'd3, nbeats: 9'd3,
                   res:  {16'd0, 16'd0, 16'hB1E0, 16'd20000},
                   expv: {16'd0, 16'd0, 16'd0, 16'd32767}, exp_sat: 4'b0001};
        tbl[3] = '{k: 8'd2, nbeats: 9'd2,
                   res:  {16'd32767, 16'h8000, 16'd7, 16'hFFFB},
                   expv: {16'd32767, 16'd0, 16'd14, 16'd0}, exp_sat: 4'b1000};
        tbl[4] = '{k: 8'd1, nbeats: 9'd1,
                   res:  {16'h8000, 16'd0, 16'd100, 16'hFFFF},
                   expv: {16'd0, 16'd0, 16'd100, 16'd0}, exp_sat: 4'b0000};
`else
        tbl[1] = '{k: 8'd3, nbeats: 9'd3,
                   res:  {16'd0, 16'd0, 16'hB1E0, 16'd20000},
                   expv: {16'd0, 16'd0, 16'h8000, 16'd32767}, exp_sat: 4'b0011};
        tbl[3] = '{k: 8'd2, nbeats: 9'd2,
                   res:  {16'd32767, 16'h8000, 16'd7, 16'hFFFB},
                   expv: {16'd32767, 16'h8000, 16'd14, 16'hFFF6}, exp_sat: 4'b1100};
        tbl[4] = '{k: 8'd1, nbeats: 9'd1,
                   res:  {16'h8000, 16'd0, 16'd100, 16'hFFFF},
                   expv: {16'h8000, 16'd0, 16'd100, 16'hFFFF}, exp_sat: 4'b0000};
`endif

        // Power-on reset.
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        k_drive = 8'd4; cfg_k_steps = 8'd4;
        for (int n = 0; n < 4; n++) res_cur[n] = '0;
        repeat (2) @(posedge clk);
        model_step();

        do_cycle(1'b0, 1'b0, zero_res, 1'b0);
        check("reset out_valid", snap_valid, 1'b0);
        check("reset out_data", snap_data, 64'd0);
        check("reset out_sat", snap_sat, 4'd0);
        check("reset busy", snap_busy, 1'b0);
        check("reset in_ready", in_ready, 1'b1);

        // Table-driven tiles.
        for (int t = 0; t < 5; t++) begin
            bit early = 1'b0;
            g0 = got.size();
            k_drive = tbl[t].k;
            for (int b = 0; b < int'(tbl[t].nbeats); b++) begin
                do_cycle(1'b0, 1'b1, tbl[t].res, 1'b0);
                if (b > 0 && snap_valid) early = 1'b1;
            end
            do_cycle(1'b0, 1'b0, zero_res, 1'b1);
            check($sformatf("vec%0d early valid", t), early, 1'b0);
            check($sformatf("vec%0d valid t+1", t), snap_valid, 1'b1);
            check($sformatf("vec%0d data", t), snap_data, pack_lanes(tbl[t].expv));
            check($sformatf("vec%0d sat", t), snap_sat, tbl[t].exp_sat);
            do_cycle(1'b0, 1'b0, zero_res, 1'b1);
            check($sformatf("vec%0d word count", t), got.size() - g0, 1);
        end

        // Backpressure: single-step tiles with the consumer stalled.
        k_drive = 8'd1;
        g0 = got.size();
        do_cycle(1'b0, 1'b1, {16'd0, 16'd0, 16'd0, 16'd1}, 1'b0);
        do_cycle(1'b0, 1'b1, {16'd0, 16'd0, 16'd0, 16'd2}, 1'b0);
        do_cycle(1'b0, 1'b1, {16'd0, 16'd0, 16'd0, 16'd3}, 1'b0);
        check("bp in_ready full", in_ready, 1'b0);
        do_cycle(1'b0, 1'b1, {16'd0, 16'd0, 16'd0, 16'd3}, 1'b0);
        do_cycle(1'b0, 1'b1, {16'd0, 16'd0, 16'd0, 16'd3}, 1'b1);
        check("bp in_ready during pop", in_ready, 1'b0);
        do_cycle(1'b0, 1'b1, {16'd0, 16'd0, 16'd0, 16'd3}, 1'b1);
        check("bp in_ready after pop", in_ready, 1'b1);
        do_cycle(1'b0, 1'b0, zero_res, 1'b1);
        do_cycle(1'b0, 1'b0, zero_res, 1'b1);
        check("bp word count", got.size() - g0, 3);
        if (got.size() - g0 == 3) begin
            check("bp word0", got[g0].data, 64'd1);
            check("bp word1", got[g0+1].data, 64'd2);
            check("bp word2", got[g0+2].data, 64'd3);
        end

        // Reset in the middle of a tile.
        k_drive = 8'd4;
        g0 = got.size();
        do_cycle(1'b0, 1'b1, {16'd100, 16'd100, 16'd100, 16'd100}, 1'b1);
        do_cycle(1'b0, 1'b1, {16'd100, 16'd100, 16'd100, 16'd100}, 1'b1);
        do_cycle(1'b1, 1'b0, zero_res, 1'b1);
        do_cycle(1'b0, 1'b0, zero_res, 1'b1);
        check("mid rst out_valid", snap_valid, 1'b0);
        check("mid rst out_data", snap_data, 64'd0);
        check("mid rst out_sat", snap_sat, 4'd0);
        check("mid rst busy", snap_busy, 1'b0);
        check("mid rst in_ready", in_ready, 1'b1);
        for (int b = 0; b < 4; b++) do_cycle(1'b0, 1'b1, tbl[0].res, 1'b1);
        do_cycle(1'b0, 1'b0, zero_res, 1'b1);
        do_cycle(1'b0, 1'b0, zero_res, 1'b1);
        check("mid rst word count", got.size() - g0, 1);
        if (got.size() - g0 == 1) check("mid rst word", got[g0].data, pack_lanes(tbl[0].expv));

        // Bubbles of 0..5 cycles and a length change mid-tile.
        k_drive = 8'd4;
        g0 = got.size();
        for (int i = 1; i <= 6; i++) begin
            r = {16'(i), 16'(i), 16'(i), 16'(i)};
            do_cycle(1'b0, 1'b1, r, 1'b1);
            if (i == 2) k_drive = 8'd2;
            for (int g = 0; g < i - 1; g++) do_cycle(1'b0, 1'b0, zero_res, 1'b1);
        end
        do_cycle(1'b0, 1'b0, zero_res, 1'b1);
        do_cycle(1'b0, 1'b0, zero_res, 1'b1);
        check("bubble word count", got.size() - g0, 2);
        if (got.size() - g0 == 2) begin
            check("bubble tile k=4", got[g0].data, {16'd10, 16'd10, 16'd10, 16'd10});
            check("bubble tile k=2", got[g0+1].data, {16'd11, 16'd11, 16'd11, 16'd11});
        end

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) k_drive = 8'($urandom_range(0, 6));
            for (int n = 0; n < 4; n++) begin
                case ($urandom_range(0, 3))
                    0:       r[n] = 16'h7FFF - 16'($urandom_range(0, 50));
                    1:       r[n] = 16'h8000 + 16'($urandom_range(0, 50));
                    default: r[n] = 16'($urandom);
                endcase
            end
            do_cycle(($urandom_range(0, 599) == 0), ($urandom_range(0, 3) != 0), r,
                     ($urandom_range(0, 2) != 0));
        end
        for (int c = 0; c < 8; c++) do_cycle(1'b0, 1'b0, zero_res, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
